ahb_lite_master: RTL
====================

# ahb_lite_master

Single-transfer AHB-Lite master. Converts a valid/ready command stream into pipelined NONSEQ transfers on an AHB-Lite bus and returns one in-order response per command. It is the initiator-side counterpart of the team's AHB SRAM and peripheral slaves, and is used by test engines and simple bus-mastering blocks (loaders, DMA front-ends).

## Interface
- CHECK_ALIGN, default 1: when 1, misaligned commands are rejected locally without a bus transfer; when 0, only cmd_size==3 is rejected.

- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted at the rising edge where cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- cmd_wdata  in  32  write data, already lane-positioned (little-endian)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  HRDATA captured (0 for writes and rejected commands)
- rsp_err  out  1  1 = ERROR response or local reject
- busy  out  1  address or data phase occupied
- HADDR  out  32, HTRANS  out  2, HWRITE  out  1, HSIZE  out  3, HBURST  out  3 (const 3'b000), HPROT  out  4 (const 4'b0011), HMASTLOCK  out  1 (const 0), HWDATA  out  32
- HREADY  in  1, HRESP  in  1, HRDATA  in  32

## Operation
- Two pipeline slots: address slot (A) and data slot (D). Each slot holds addr, write, size, wdata, and a reject flag.
- cmd_ready = (~A.valid | HREADY) & ~err_cancel. A command is accepted only when the A slot is empty or its address phase completes on the same edge.
- A slot is driven combinationally from registers: HTRANS=2'b10 (NONSEQ) for a normal command, 2'b00 (IDLE) for an empty slot or a rejected command. HADDR, HWRITE, and HSIZE are held stable while HTRANS is NONSEQ and HREADY is 0.
- Rejection: cmd_size==3. With CHECK_ALIGN=1, also half with addr[0]=1 and word with addr[1:0]!=0. A rejected command flows through both slots as an IDLE transfer so responses stay in order; its response has rsp_err=1 and rsp_rdata=0.
- Address phase completes on an edge with HREADY=1: A moves to D, and HWDATA=D.wdata for the whole D cycle(s). HWDATA holds its last value when D is not a write.
- Data phase completes on an edge with HREADY=1. In the next cycle: rsp_valid=1, rsp_err=HRESP (forced 1 if rejected), rsp_rdata=HRDATA for a non-rejected read, else 0. There is no response backpressure.
- Error handling: when D is a non-rejected transfer and HRESP=1 with HREADY=0 (first error cycle), the next cycle drives HTRANS=IDLE for the command in A and sets err_cancel. When the error completes (HREADY=1), that command stays in A and is re-issued as NONSEQ in the following cycle. err_cancel then clears. A command is never dropped or reordered.
- busy = A.valid | D.valid.

## Timing
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. cmd_ready is 1 once HRESETn is released.
- Latency with zero wait states: accept at edge N, NONSEQ in cycle N+1, data phase in N+2, rsp_valid in N+3.
- Throughput is 1 command/cycle with zero wait states. Each HREADY=0 cycle adds one cycle to both slots.
- An ERROR response costs 2 cycles in data phase. A cancelled follower is re-issued 1 cycle after the error completes.
- Simultaneous events: accept and address-phase completion on the same edge is allowed. Data-phase completion and response on the same edge as the next completion is allowed, giving back-to-back rsp_valid.
- Asserting HRESETn mid-transfer clears both slots immediately; in-flight responses are lost. The bus shows IDLE while reset is held.

## Test plan
- Word write 0x0000_0010 ← 0xDEADBEEF, HREADY=1: NONSEQ, HSIZE=010, HWRITE=1 in cycle N+1; HWDATA=0xDEADBEEF in N+2; rsp_valid, rsp_err=0 in N+3.
- Byte read 0x0000_0003 with slave stalling 2 cycles, HRDATA=0xAB00_0000: HADDR held stable; rsp_valid 5 cycles after accept with rsp_rdata=0xAB00_0000.
- Three back-to-back word writes to 0x0, 0x4, 0x8, zero wait: three consecutive NONSEQ cycles, HWDATA aligned one cycle later, three consecutive rsp_valid pulses.
- Read 0x100 gets ERROR (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) with a write to 0x104 queued: HTRANS=IDLE in the second error cycle, 0x104 re-issued as NONSEQ the next cycle; responses in order are err=1, then err=0.
- CHECK_ALIGN=1, half read at 0x0000_0001 between two valid reads: no NONSEQ for it; three responses in order with the middle one err=1, rdata=0.
- Reset asserted during the data phase of a read: outputs return to reset values; no rsp_valid after release; a new command completes normally.

Source files
------------

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite master: turns a valid/ready command stream into
// pipelined NONSEQ transfers and returns one in-order response per command.
module ahb_lite_master #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,

    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA
);

    localparam logic [1:0] TRANS_IDLE    = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ  = 2'b10;

    logic        a_valid;
    logic        a_write;
    logic        a_rej;
    logic [1:0]  a_size;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;

    logic        d_valid;
    logic        d_write;
    logic        d_rej;

    logic [31:0] hwdata_q;
    logic        err_cancel;

    logic        cmd_rej;
    logic        accept;
    logic        a_advance;
    logic        d_done;

    // Rejected commands still occupy both slots as IDLE transfers so that
    // their responses stay in order with the real ones.
    always_comb begin
        cmd_rej = (cmd_size == 2'd3);
        if (CHECK_ALIGN) begin
            if ((cmd_size == 2'd1) && cmd_addr[0])
                cmd_rej = 1'b1;
            if ((cmd_size == 2'd2) && (cmd_addr[1:0] != 2'b00))
                cmd_rej = 1'b1;
        end
    end

    assign cmd_ready = (~a_valid | HREADY) & ~err_cancel;
    assign accept    = cmd_valid & cmd_ready;
    assign a_advance = a_valid & HREADY & ~err_cancel;
    assign d_done    = d_valid & HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid    <= 1'b0;
            a_write    <= 1'b0;
            a_rej      <= 1'b0;
            a_size     <= 2'b00;
            a_addr     <= 32'h0;
            a_wdata    <= 32'h0;
            d_valid    <= 1'b0;
            d_write    <= 1'b0;
            d_rej      <= 1'b0;
            hwdata_q   <= 32'h0;
            err_cancel <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0;
        end else begin
            if (accept) begin
                a_valid <= 1'b1;
                a_write <= cmd_write;
                a_rej   <= cmd_rej;
                a_size  <= cmd_size;
                a_addr  <= cmd_addr;
                a_wdata <= cmd_wdata;
            end else if (a_advance) begin
                a_valid <= 1'b0;
            end

            if (a_advance) begin
                d_valid <= 1'b1;
                d_write <= a_write;
                d_rej   <= a_rej;
                if (a_write && !a_rej)
                    hwdata_q <= a_wdata;
            end else if (d_done) begin
                d_valid <= 1'b0;
            end

            rsp_valid <= d_done;
            rsp_err   <= d_done & (d_rej | HRESP);
            rsp_rdata <= (d_done && !d_rej && !d_write) ? HRDATA : 32'h0;

            // First ERROR cycle: pull the follower off the bus; it stays in A
            // and is re-issued once the error's second cycle completes.
            if (err_cancel) begin
                if (HREADY)
                    err_cancel <= 1'b0;
            end else if (d_valid && !d_rej && HRESP && !HREADY) begin
                err_cancel <= 1'b1;
            end
        end
    end

    assign HTRANS    = (a_valid && !a_rej && !err_cancel) ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR     = a_addr;
    assign HWRITE    = a_write;
    assign HSIZE     = {1'b0, a_size};
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign busy      = a_valid | d_valid;

endmodule
